vc_ctrl_n: RTL and testbench
============================

Name: vc_ctrl_n

Overview:
Per-input-virtual-channel packet controller, parametrised in port count and VC count.
- One instance per (input port, VC). Latches the route of each head flit, arbitrates for the selected output VC and switch, and streams the packet.
- Returns to routing when it forwards a tail or head-tail flit.
- Compared with the fixed 5-port/2-VC controller it adds: buffer-valid qualification, a same-cycle single-flit-packet path, a packet-length limit with a sticky error, and an optional starvation-priority output.

Parameters:
NPORT, 5, number of output ports.
NVCH, 2, virtual channels per port.
MAX_FLITS, 16, maximum flits per packet including head (>=2).
STARV_TH, 32, VSA wait cycles before prio asserts (>=1).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
bvld  in  1  head of input buffer holds a flit.
btype  in  2  type of buffered flit (codes from vc_pkg).
port  in  clog2(NPORT)  route-computed output port, valid with head flit.
ovch  in  clog2(NVCH)  output VC, valid with head flit.
irdy  in  NPORT*NVCH  downstream VC can accept a flit; index = p*NVCH+v.
ilck  in  NPORT*NVCH  downstream VC is locked by another input VC.
grt  in  NPORT  switch grant per output port; registered by the arbiter, no combinational path from req.
req  out  1  switch request.
send  out  1  flit forwarded and popped this cycle.
olck  out  1  this VC owns an output VC.
prio  out  1  starvation priority request.
err  out  1  sticky protocol error.

Behaviour:
- States: RC=0, VSA=1, ST=2. Registers: state, port_q, ovch_q, flit_cnt, wait_cnt, err.
- Reset: state=RC; port_q=0; ovch_q=0; counters=0; err=0. All outputs read 0 after reset.
- Selected channel index is port_q*NVCH+ovch_q.
  - sel_lck = ilck[idx]; sel_rdy = irdy[idx]; sel_grt = grt[port_q].
  - If port_q>=NPORT: sel_lck=1, sel_grt=0, sel_rdy=0.
- olck = (state!=RC), combinational.
- req = (state==VSA && !sel_lck) || (state==ST && bvld).
- send = bvld && sel_grt && sel_rdy && ((state==VSA && !sel_lck) || state==ST). No flit is sent in RC.
- RC:
  - bvld with HEAD or HEADTAIL: latch port/ovch, flit_cnt=0, go to VSA. Earliest send is the next cycle.
  - bvld with BODY or TAIL: err=1, state stays RC, flit is not popped.
  - If the latched port>=NPORT: err=1 on the same edge; the VC then sits in VSA with req=0 until rst.
- VSA:
  - If send with HEADTAIL: go to RC (single-flit packet).
  - If send with HEAD: go to ST, flit_cnt=1.
  - Otherwise stay in VSA. ilck blocks req; a missing grant or irdy only stalls.
- ST:
  - On send: flit_cnt+1. TAIL or HEADTAIL goes to RC.
  - On send of a HEAD: err=1, flit treated as a body flit.
  - If flit_cnt would reach MAX_FLITS on a non-tail send: err=1, flit forwarded, stay in ST. The counter saturates at MAX_FLITS.
- bvld=0 in ST: no send, no counter change, req=0.
- err is sticky until rst and never blocks forwarding.
- rst mid-packet: immediate return to RC; downstream is expected to be reset on the same edge.

Optional Feature:
VC_STARV_EN
- Defined:
  - wait_cnt counts cycles in VSA without send and saturates at STARV_TH.
  - prio = (state==VSA && wait_cnt==STARV_TH).
  - wait_cnt clears on leaving VSA or on rst.
- Undefined: no wait_cnt register; prio tied 0.

Decomposition:
- vc_pkg holds:
  - flit type codes: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEADTAIL=2'b11;
  - state encodings RC/VSA/ST;
  - a clog2 helper for port/VC widths.
- One sub-module, vc_chsel: combinational mux producing sel_lck/sel_rdy/sel_grt from port_q/ovch_q with range guard. Everything else stays in vc_ctrl_n.

Test Plan:
1. Head to port 2/VC 1 with irdy/grt set, then body and tail, defaults → VSA send at cycle 2, sends at cycles 3 and 4, state=RC at cycle 5; olck high for cycles 2-4.
2. HEADTAIL to port 0/VC 0 → one send in VSA, state=RC next cycle, olck high for exactly 1 cycle.
3. ilck[1*2+0]=1 with route 1/0 for 10 cycles, then cleared → req=0 for 10 cycles, req=1 after; send only once grt[1] and irdy are also set.
4. Route port=6 with NPORT=5 → err=1, req=0 permanently, send never asserts.
5. MAX_FLITS=4, packet of head plus 5 body flits plus tail → err set on the 4th flit; all flits forwarded; return to RC after the tail.
6. VC_STARV_EN, STARV_TH=8, grt held 0 → prio rises on the 9th VSA cycle; clears the cycle after the first send.

Source files
------------

// File: rtl/vc_pkg.sv
// vc_pkg: flit type codes, controller state encodings and a width helper
package vc_pkg;
    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_t;

    typedef enum logic [1:0] {
        RC  = 2'd0,
        VSA = 2'd1,
        ST  = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/vc_chsel.sv
// vc_chsel: selects lock/ready/grant of the latched output VC, out-of-range routes read as locked
module vc_chsel import vc_pkg::*; #(
    parameter int NPORT = 5,
    parameter int NVCH  = 2
) (
    input  logic [clog2(NPORT)-1:0]  port_q,
    input  logic [clog2(NVCH)-1:0]   ovch_q,
    input  logic [NPORT*NVCH-1:0]    irdy,
    input  logic [NPORT*NVCH-1:0]    ilck,
    input  logic [NPORT-1:0]         grt,
    output logic                     sel_lck,
    output logic                     sel_rdy,
    output logic                     sel_grt
);
    localparam int CW = clog2(NPORT*NVCH);
    localparam int PW = clog2(NPORT);

    logic          ok;
    logic [CW-1:0] idx;
    logic [PW-1:0] gidx;

    // Flatten the route to a channel index and force a safe "locked" view when it is out of range
    always_comb begin
        ok      = int'(port_q) < NPORT && int'(ovch_q) < NVCH;
        idx     = ok ? CW'(int'(port_q) * NVCH + int'(ovch_q)) : '0;
        gidx    = ok ? port_q : '0;
        sel_lck = ok ? ilck[idx] : 1'b1;
        sel_rdy = ok & irdy[idx];
        sel_grt = ok & grt[gidx];
    end
endmodule

// File: rtl/vc_ctrl_n.sv
// vc_ctrl_n: per-input-VC packet controller (route latch, VC/switch arbitration, streaming); VC_STARV_EN adds starvation priority
module vc_ctrl_n import vc_pkg::*; #(
    parameter int NPORT     = 5,
    parameter int NVCH      = 2,
    parameter int MAX_FLITS = 16,
    parameter int STARV_TH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bvld,
    input  logic [1:0]               btype,
    input  logic [clog2(NPORT)-1:0]  port,
    input  logic [clog2(NVCH)-1:0]   ovch,
    input  logic [NPORT*NVCH-1:0]    irdy,
    input  logic [NPORT*NVCH-1:0]    ilck,
    input  logic [NPORT-1:0]         grt,
    output logic                     req,
    output logic                     send,
    output logic                     olck,
    output logic                     prio,
    output logic                     err
);
    localparam int PW = clog2(NPORT);
    localparam int VW = clog2(NVCH);
    localparam int FW = clog2(MAX_FLITS + 1);

    if (MAX_FLITS < 2 || STARV_TH < 1) begin : g_bad_param
        $error("vc_ctrl_n: MAX_FLITS must be >= 2 and STARV_TH >= 1");
    end

    state_t        state, state_n;
    logic [PW-1:0] port_q;
    logic [VW-1:0] ovch_q;
    logic [FW-1:0] flit_cnt, flit_cnt_n;
    logic          err_n, sel_lck, sel_rdy, sel_grt, vsa_go, is_head, is_tail, at_max;

    vc_chsel #(.NPORT(NPORT), .NVCH(NVCH)) u_chsel (
        .port_q  (port_q),
        .ovch_q  (ovch_q),
        .irdy    (irdy),
        .ilck    (ilck),
        .grt     (grt),
        .sel_lck (sel_lck),
        .sel_rdy (sel_rdy),
        .sel_grt (sel_grt)
    );

    // Handshake outputs and next-state/counter/error decisions
    always_comb begin
        is_head    = btype == HEAD || btype == HEADTAIL;
        is_tail    = btype == TAIL || btype == HEADTAIL;
        at_max     = int'(flit_cnt) + 1 >= MAX_FLITS;
        vsa_go     = state == VSA && !sel_lck;
        olck       = state != RC;
        req        = vsa_go || (state == ST && bvld);
        send       = bvld && sel_grt && sel_rdy && (vsa_go || state == ST);
        state_n    = state;
        flit_cnt_n = flit_cnt;
        err_n      = err;
        if (state == RC) begin
            if (bvld && is_head) begin
                state_n    = VSA;
                flit_cnt_n = '0;
                err_n      = err || int'(port) >= NPORT;
            end else if (bvld) begin
                err_n = 1'b1;
            end
        end else if (state == VSA) begin
            if (send) begin
                state_n    = is_tail ? RC : ST;
                flit_cnt_n = FW'(1);
            end
        end else if (send) begin
            flit_cnt_n = at_max ? FW'(MAX_FLITS) : flit_cnt + 1'b1;
            err_n      = err || btype == HEAD || (!is_tail && at_max);
            state_n    = is_tail ? RC : ST;
        end
    end

    // State, latched route, flit counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RC;
            port_q   <= '0;
            ovch_q   <= '0;
            flit_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            flit_cnt <= flit_cnt_n;
            err      <= err_n;
            if (state == RC && bvld && is_head) begin
                port_q <= port;
                ovch_q <= ovch;
            end
        end
    end

`ifdef VC_STARV_EN
    localparam int WW = clog2(STARV_TH + 1);
    logic [WW-1:0] wait_cnt;

    // Count VSA cycles without forwarding, saturating at the threshold
    always_ff @(posedge clk) begin
        if (rst || state != VSA || send)
            wait_cnt <= '0;
        else if (int'(wait_cnt) < STARV_TH)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign prio = state == VSA && int'(wait_cnt) == STARV_TH;
`else
    assign prio = 1'b0;
`endif
endmodule

// File: tb/tb_vc_ctrl_n.sv
// tb_vc_ctrl_n: vector table, corner-case sequences and randomized run against a packet-level model
module tb_vc_ctrl_n;
    import vc_pkg::*;

    localparam int NP = 5, NV = 2, MF = 4, TH = 8, NC = NP * NV;
`ifdef VC_STARV_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, bvld;
    logic [1:0]    btype;
    logic [2:0]    port;
    logic [0:0]    ovch;
    logic [NC-1:0] irdy, ilck;
    logic [NP-1:0] grt;
    logic          req, send, olck, prio, err;
    int            nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    vc_ctrl_n #(.NPORT(NP), .NVCH(NV), .MAX_FLITS(MF), .STARV_TH(TH)) dut (
        .clk(clk), .rst(rst), .bvld(bvld), .btype(btype), .port(port), .ovch(ovch),
        .irdy(irdy), .ilck(ilck), .grt(grt),
        .req(req), .send(send), .olck(olck), .prio(prio), .err(err)
    );

    typedef struct {
        logic          r, v;
        logic [1:0]    t;
        logic [2:0]    p;
        logic          o;
        logic [NC-1:0] rdy;
        logic [NP-1:0] g;
        logic          e_req, e_send, e_olck, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, v, input logic [1:0] t, input int p, o,
                                input logic rdy, g, e_req, e_send, e_olck, e_err);
        vec_t x;
        x.r = r; x.v = v; x.t = t; x.p = 3'(p); x.o = 1'(o);
        x.rdy = rdy ? '1 : '0; x.g = g ? '1 : '0;
        x.e_req = e_req; x.e_send = e_send; x.e_olck = e_olck; x.e_err = e_err;
        return x;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1; bvld = 1'b0; btype = BODY; port = '0; ovch = '0;
        irdy = '0; ilck = '0; grt = '0;
        tick();
        rst = 1'b0;
    endtask

    // Packet-level reference: "holding a route" and "head already forwarded"
    bit m_route, m_stream, m_err;
    int m_port, m_ovch, m_len, m_wait;

    task automatic model_reset;
        m_route = 0; m_stream = 0; m_err = 0; m_port = 0; m_ovch = 0; m_len = 0; m_wait = 0;
    endtask

    task automatic model_cycle;
        bit inr, lck, rdy, g, waiting, e_req, e_send, hd, tl;
        int ch;
        inr     = m_port < NP;
        ch      = inr ? m_port * NV + m_ovch : 0;
        lck     = inr ? ilck[ch] : 1'b1;
        rdy     = inr ? irdy[ch] : 1'b0;
        g       = inr ? grt[m_port] : 1'b0;
        waiting = m_route && !m_stream;
        e_req   = (waiting && !lck) || (m_stream && bvld);
        e_send  = bvld && g && rdy && ((waiting && !lck) || m_stream);
        chk("rnd_req", req, e_req);
        chk("rnd_send", send, e_send);
        chk("rnd_olck", olck, m_route);
        chk("rnd_err", err, m_err);
        chk("rnd_prio", prio, SE && waiting && m_wait >= TH);
        hd = btype == HEAD || btype == HEADTAIL;
        tl = btype == TAIL || btype == HEADTAIL;
        if (rst) begin
            model_reset();
        end else if (!m_route) begin
            m_wait = 0;
            if (bvld && hd) begin
                m_route = 1; m_port = int'(port); m_ovch = int'(ovch); m_len = 0;
                if (m_port >= NP) m_err = 1;
            end else if (bvld) begin
                m_err = 1;
            end
        end else if (waiting) begin
            if (e_send) begin
                if (tl) m_route = 0;
                else begin m_stream = 1; m_len = 1; end
                m_wait = 0;
            end else if (m_wait < TH) begin
                m_wait++;
            end
        end else if (e_send) begin
            m_len++;
            if (btype == HEAD) m_err = 1;
            if (tl) begin m_route = 0; m_stream = 0; end
            else if (m_len >= MF) m_err = 1;
        end
    endtask

    initial begin
        do_reset();
        settle();
        chk("rst_req", req, 1'b0);
        chk("rst_send", send, 1'b0);
        chk("rst_olck", olck, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_prio", prio, 1'b0);
        tick();

        // Normal packet with a stall, single-flit packet, grant/ready stalls, protocol error, reset
        tbl.push_back(mk(0, 1, HEAD,     2, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, HEAD,     2, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, BODY,     0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, BODY,     0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, TAIL,     0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, HEAD,     0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, HEADTAIL, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, HEADTAIL, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, BODY,     0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, HEAD,     3, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, HEAD,     3, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, HEAD,     3, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, TAIL,     3, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, TAIL,     3, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, BODY,     0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, TAIL,     0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, BODY,     0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, BODY,     0, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; bvld = tbl[i].v; btype = tbl[i].t; port = tbl[i].p;
            ovch = tbl[i].o; irdy = tbl[i].rdy; ilck = '0; grt = tbl[i].g;
            settle();
            chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
            chk($sformatf("tbl%0d_send", i), send, tbl[i].e_send);
            chk($sformatf("tbl%0d_olck", i), olck, tbl[i].e_olck);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("tbl%0d_prio", i), prio, 1'b0);
            tick();
        end

        // Locked output VC blocks req; send waits for grant and ready as well
        do_reset();
        bvld = 1'b1; btype = HEAD; port = 3'd1; ovch = 1'b0; ilck = '0; ilck[2] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("lck_req", req, 1'b0);
            chk("lck_send", send, 1'b0);
            tick();
        end
        ilck = '0;
        settle();
        chk("unlck_req", req, 1'b1);
        chk("unlck_send", send, 1'b0);
        tick();
        grt[1] = 1'b1;
        settle();
        chk("grt_nordy_send", send, 1'b0);
        tick();
        irdy[2] = 1'b1;
        settle();
        chk("grt_rdy_send", send, 1'b1);
        tick();
        bvld = 1'b0;
        settle();
        chk("lck_st_olck", olck, 1'b1);
        chk("lck_st_req", req, 1'b0);

        // Route to a non-existent port: error, never requests or sends
        do_reset();
        bvld = 1'b1; btype = HEAD; port = 3'd6; ovch = 1'b0; irdy = '1; grt = '1;
        settle();
        chk("badport_err0", err, 1'b0);
        tick();
        btype = BODY;
        for (int i = 0; i < 12; i++) begin
            settle();
            chk("badport_err", err, 1'b1);
            chk("badport_req", req, 1'b0);
            chk("badport_send", send, 1'b0);
            chk("badport_olck", olck, 1'b1);
            tick();
        end

        // Over-length packet: error after the MF-th flit, all flits forwarded
        do_reset();
        bvld = 1'b1; btype = HEAD; port = 3'd4; ovch = 1'b1; irdy = '1; grt = '1;
        tick();
        for (int i = 0; i < 7; i++) begin
            btype = (i == 0) ? HEAD : (i == 6) ? TAIL : BODY;
            settle();
            chk("len_send", send, 1'b1);
            chk("len_err", err, i >= MF);
            tick();
        end
        bvld = 1'b0;
        settle();
        chk("len_done_olck", olck, 1'b0);
        chk("len_done_err", err, 1'b1);

        // Starvation priority under a withheld grant
        do_reset();
        bvld = 1'b1; btype = HEAD; port = 3'd0; ovch = 1'b0; irdy = '1; grt = '0;
        tick();
        for (int k = 1; k <= 12; k++) begin
            settle();
            chk($sformatf("starv_prio_c%0d", k), prio, SE && k >= TH + 1);
            tick();
        end
        grt = '1;
        settle();
        chk("starv_send", send, 1'b1);
        chk("starv_prio_at_send", prio, SE);
        tick();
        btype = TAIL;
        settle();
        chk("starv_prio_after", prio, 1'b0);

        // Randomized traffic against the packet-level model
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            rst   = $urandom_range(0, 59) == 0;
            bvld  = $urandom_range(0, 3) != 0;
            btype = 2'($urandom_range(0, 3));
            port  = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            ovch  = 1'($urandom_range(0, 1));
            irdy  = NC'($urandom | $urandom);
            ilck  = NC'($urandom & $urandom & $urandom);
            grt   = NP'($urandom | $urandom);
            settle();
            model_cycle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
